// File: rtl/dsp_slice_pkg.sv
// Shared constants for the DSP slice multiplier path.
// Widths of the multiplier operands/products, the B operand split point used
// when the product is formed as two partial products, and the legal values of
// the MREG / USE_MULT configuration parameters.
package dsp_slice_pkg;

    localparam int AMULT_W = 25;
    localparam int BMULT_W = 18;
    localparam int M_W     = 43;
    localparam int B_SPLIT = 9;

    localparam int MREG_COMB = 0;
    localparam int MREG_REG  = 1;

    localparam string USE_MULT_MULTIPLY = "MULTIPLY";
    localparam string USE_MULT_NONE     = "NONE";

    // Sign-extend the 25-bit multiplicand to the full product width.
    function automatic logic [M_W-1:0] sext_amult(input logic [AMULT_W-1:0] a);
        return {{(M_W-AMULT_W){a[AMULT_W-1]}}, a};
    endfunction

    // Sign-extend the 18-bit multiplier to the full product width.
    function automatic logic [M_W-1:0] sext_bmult(input logic [BMULT_W-1:0] b);
        return {{(M_W-BMULT_W){b[BMULT_W-1]}}, b};
    endfunction

endpackage

// File: rtl/mult_stage_pp_gen.sv
// mult_pp_gen: combinational product generator for the multiplier stage.
// Build option: MULT_STAGE_PARTIAL_PRODUCTS_EN
//   defined   -> M1 = A * signed(B[17:9]) << 9, M2 = A * unsigned(B[8:0])
//   undefined -> M1 = full product, M2 = 0
// In both builds M1 + M2 (mod 2^43) equals the exact signed product and
// MSIGN is the sign bit of that product.
module mult_pp_gen
    import dsp_slice_pkg::*;
(
    input  logic [AMULT_W-1:0] amult,
    input  logic [BMULT_W-1:0] bmult,
    output logic [M_W-1:0]     m1,
    output logic [M_W-1:0]     m2,
    output logic               msign
);

    logic [M_W-1:0] a_ext;
    logic [M_W-1:0] b_ext;
    logic [M_W-1:0] full_prod;

    assign a_ext = sext_amult(amult);
    assign b_ext = sext_bmult(bmult);

    // 43-bit truncated multiply of sign-extended operands is the exact product,
    // since a 25x18 signed product always fits in 43 bits.
    assign full_prod = a_ext * b_ext;
    assign msign     = full_prod[M_W-1];

`ifdef MULT_STAGE_PARTIAL_PRODUCTS_EN
    logic [M_W-1:0] b_hi_ext;
    logic [M_W-1:0] b_lo_ext;
    logic [M_W-1:0] hi_prod;

    // Upper slice of B carries the sign; lower slice is a plain magnitude.
    assign b_hi_ext = {{(M_W-(BMULT_W-B_SPLIT)){bmult[BMULT_W-1]}}, bmult[BMULT_W-1:B_SPLIT]};
    assign b_lo_ext = {{(M_W-B_SPLIT){1'b0}}, bmult[B_SPLIT-1:0]};
    assign hi_prod  = a_ext * b_hi_ext;

    assign m1 = hi_prod << B_SPLIT;
    assign m2 = a_ext * b_lo_ext;
`else
    assign m1 = full_prod;
    assign m2 = '0;
`endif

endmodule

// File: rtl/mult_stage.sv
// mult_stage: signed 25x18 multiplier stage with optional M pipeline register.
// Build option: MULT_STAGE_PARTIAL_PRODUCTS_EN selects the two-partial-product
// form of M1/M2 (see mult_pp_gen); the sum M1 + M2 is the product either way.
// MREG = 1 registers M1/M2/MSIGN (CEM enable, RSTM synchronous clear with
// priority); MREG = 0 passes the combinational result straight through.
// USE_MULT = "NONE" forces all outputs to zero.
module mult_stage
    import dsp_slice_pkg::*;
#(
    parameter int    MREG     = 1,
    parameter string USE_MULT = "MULTIPLY"
) (
    input  logic               clk,
    input  logic               RSTM,
    input  logic               CEM,
    input  logic [AMULT_W-1:0] AMULT,
    input  logic [BMULT_W-1:0] BMULT,
    output logic [M_W-1:0]     M1,
    output logic [M_W-1:0]     M2,
    output logic               MSIGN
);

    localparam bit MULT_EN = (USE_MULT == USE_MULT_MULTIPLY);

    // Reject unsupported configurations at elaboration time.
    generate
        if ((MREG != MREG_COMB) && (MREG != MREG_REG)) begin : g_bad_mreg
            $error("mult_stage: MREG must be 0 or 1");
        end
        if ((USE_MULT != USE_MULT_MULTIPLY) && (USE_MULT != USE_MULT_NONE)) begin : g_bad_use_mult
            $error("mult_stage: USE_MULT must be \"MULTIPLY\" or \"NONE\"");
        end
    endgenerate

    logic [M_W-1:0] pp_m1;
    logic [M_W-1:0] pp_m2;
    logic           pp_msign;

    mult_pp_gen u_pp_gen (
        .amult (AMULT),
        .bmult (BMULT),
        .m1    (pp_m1),
        .m2    (pp_m2),
        .msign (pp_msign)
    );

    logic [M_W-1:0] m1_next;
    logic [M_W-1:0] m2_next;
    logic           msign_next;

    // Gate the product to zero when the multiplier is disabled.
    always_comb begin
        m1_next    = '0;
        m2_next    = '0;
        msign_next = 1'b0;
        if (MULT_EN) begin
            m1_next    = pp_m1;
            m2_next    = pp_m2;
            msign_next = pp_msign;
        end
    end

    logic [M_W-1:0] m1_reg;
    logic [M_W-1:0] m2_reg;
    logic           msign_reg;

    // M pipeline register: clear has priority over the clock enable.
    always_ff @(posedge clk) begin
        if (RSTM) begin
            m1_reg    <= '0;
            m2_reg    <= '0;
            msign_reg <= 1'b0;
        end else if (CEM) begin
            m1_reg    <= m1_next;
            m2_reg    <= m2_next;
            msign_reg <= msign_next;
        end
    end

    // Output select: registered or combinational path.
    generate
        if (MREG == MREG_REG) begin : g_mreg
            assign M1    = m1_reg;
            assign M2    = m2_reg;
            assign MSIGN = msign_reg;
        end else begin : g_comb
            assign M1    = m1_next;
            assign M2    = m2_next;
            assign MSIGN = msign_next;
        end
    endgenerate

endmodule
